// File: rtl/iq_stream_framer.sv
// rtl/iq_stream_framer.sv - frames a snapshot of packed I/Q samples into a UART byte stream
// Optional trailing checksum byte: define IQ_STREAM_FRAMER_CHECKSUM_EN.
module iq_stream_framer #(
    parameter int          N_CH         = 2,
    parameter int          SAMPLE_WIDTH = 16,
    parameter logic [7:0]  FRAME_ID     = 8'h01
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_en,
    input  logic                           i_dclk,
    input  logic [N_CH*2*SAMPLE_WIDTH-1:0] i_data,
    input  logic                           i_tx_busy,
    output logic                           o_tx_start,
    output logic [7:0]                     o_tx_byte,
    output logic                           o_busy,
    output logic [7:0]                     o_drop_cnt
);

    localparam int DW = N_CH * 2 * SAMPLE_WIDTH;
    localparam int NB = DW / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_ID,
        S_SEQ,
        S_PAYLOAD
`ifdef IQ_STREAM_FRAMER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    typedef enum logic [1:0] {
        P_ISSUE,
        P_WAIT_HI,
        P_WAIT_LO
    } phase_t;

    state_t          state;
    state_t          state_nxt;
    phase_t          phase;
    phase_t          phase_nxt;
    logic            dclk_q;
    logic            armed;
    logic [7:0]      seq;
    logic [IW-1:0]   pidx;
    logic [DW-1:0]   snapshot;
    logic [7:0]      drop_cnt;
    logic [7:0]      byte_mux;
    logic            frame_done;
    logic            request;
    logic            advance;
    logic            last_payload;
`ifdef IQ_STREAM_FRAMER_CHECKSUM_EN
    logic [7:0]      acc;
`endif

    // armed stays low after reset until i_dclk is seen low, so a level already high at release is not an edge
    assign request      = i_dclk && !dclk_q && i_en && armed;
    assign advance      = (phase == P_WAIT_LO) && !i_tx_busy;
    assign last_payload = (pidx == IW'(NB - 1));

    assign o_tx_start = (state != S_IDLE) && (phase == P_ISSUE);
    assign o_tx_byte  = byte_mux;
    assign o_busy     = (state != S_IDLE);
    assign o_drop_cnt = drop_cnt;

    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase;
        byte_mux   = 8'h00;
        frame_done = 1'b0;

        case (phase)
            P_ISSUE:   phase_nxt = P_WAIT_HI;
            P_WAIT_HI: if (i_tx_busy)  phase_nxt = P_WAIT_LO;
            P_WAIT_LO: if (!i_tx_busy) phase_nxt = P_ISSUE;
            default:   phase_nxt = P_ISSUE;
        endcase

        case (state)
            S_IDLE: begin
                phase_nxt = P_ISSUE;
                if (request) state_nxt = S_SOF;
            end
            S_SOF: begin
                byte_mux = 8'hAA;
                if (advance) state_nxt = S_ID;
            end
            S_ID: begin
                byte_mux = FRAME_ID;
                if (advance) state_nxt = S_SEQ;
            end
            S_SEQ: begin
                byte_mux = seq;
                if (advance) state_nxt = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                // snapshot shifts left per byte, so the current byte is always at the top
                byte_mux = snapshot[DW-1 -: 8];
                if (advance && last_payload) begin
`ifdef IQ_STREAM_FRAMER_CHECKSUM_EN
                    state_nxt = S_CSUM;
`else
                    state_nxt  = S_IDLE;
                    frame_done = 1'b1;
`endif
                end
            end
`ifdef IQ_STREAM_FRAMER_CHECKSUM_EN
            S_CSUM: begin
                byte_mux = 8'h00 - acc;
                if (advance) begin
                    state_nxt  = S_IDLE;
                    frame_done = 1'b1;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            phase    <= P_ISSUE;
            dclk_q   <= 1'b0;
            armed    <= 1'b0;
            seq      <= 8'h00;
            pidx     <= '0;
            snapshot <= '0;
            drop_cnt <= 8'h00;
`ifdef IQ_STREAM_FRAMER_CHECKSUM_EN
            acc      <= 8'h00;
`endif
        end else begin
            state  <= state_nxt;
            phase  <= phase_nxt;
            dclk_q <= i_dclk;
            if (!i_dclk) armed <= 1'b1;

            if (request && state == S_IDLE) begin
                snapshot <= i_data;
`ifdef IQ_STREAM_FRAMER_CHECKSUM_EN
                acc      <= 8'h00;
`endif
            end

            if (request && state != S_IDLE && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;

            if (state == S_SEQ && advance)
                pidx <= '0;

            if (state == S_PAYLOAD && advance) begin
                snapshot <= snapshot << 8;
                if (!last_payload) pidx <= pidx + IW'(1);
            end

`ifdef IQ_STREAM_FRAMER_CHECKSUM_EN
            if (phase == P_ISSUE && (state == S_ID || state == S_SEQ || state == S_PAYLOAD))
                acc <= acc + byte_mux;
`endif

            if (frame_done) seq <= seq + 8'd1;
        end
    end

endmodule

// File: tb/tb_iq_stream_framer.sv
// tb/tb_iq_stream_framer.sv - scoreboard bench for iq_stream_framer with a UART busy model
module tb_iq_stream_framer;

`ifdef IQ_STREAM_FRAMER_CHECKSUM_EN
    localparam int FL = 12;
`else
    localparam int FL = 11;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        dclk;
    logic [63:0] data;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic        busy;
    logic [7:0]  drop_cnt;

    logic        u_busy;
    logic        u_dly;
    int          u_hold;
    logic        stall;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  model_seq;
    int          frame_pos;
    logic [7:0]  seen_seq;
    logic [7:0]  held;
    logic [7:0]  exp_b;

    iq_stream_framer #(.N_CH(2), .SAMPLE_WIDTH(16), .FRAME_ID(8'h01)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_dclk     (dclk),
        .i_data     (data),
        .i_tx_busy  (tx_busy),
        .o_tx_start (tx_start),
        .o_tx_byte  (tx_byte),
        .o_busy     (busy),
        .o_drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // UART: busy rises one cycle after the start pulse and stays high for 10 cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_busy <= 1'b0;
            u_dly  <= 1'b0;
            u_hold <= 0;
        end else begin
            u_dly <= tx_start;
            if (u_dly) begin
                u_busy <= 1'b1;
                u_hold <= 9;
            end else if (u_busy) begin
                if (u_hold == 0) u_busy <= 1'b0;
                else             u_hold <= u_hold - 1;
            end
        end
    end
    assign tx_busy = u_busy | stall;

    always @(negedge clk) begin
        if (!rst_n) begin
            frame_pos = 0;
            exp_q.delete();
        end else if (tx_start) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_start actual=%02h required=no_start", tx_byte);
            end else begin
                exp_b = exp_q.pop_front();
                if (tx_byte !== exp_b) begin
                    errors++;
                    $display("FAIL tx_byte pos=%0d actual=%02h required=%02h", frame_pos, tx_byte, exp_b);
                end
            end
            if (frame_pos == 2) seen_seq = tx_byte;
            frame_pos = (frame_pos == FL - 1) ? 0 : frame_pos + 1;
            held = tx_byte;
        end else if (busy) begin
            checks++;
            if (tx_byte !== held) begin
                errors++;
                $display("FAIL byte_stable actual=%02h required=%02h", tx_byte, held);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference frame: header, payload MSB first, optional two's-complement checksum
    task automatic push_frame(input logic [63:0] d);
        logic [63:0] t;
        logic [7:0]  s;
        logic [7:0]  b;
        t = d;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h01);
        exp_q.push_back(model_seq);
        s = 8'h01 + model_seq;
        for (int k = 0; k < 8; k++) begin
            b = t[63:56];
            exp_q.push_back(b);
            s = s + b;
            t = t << 8;
        end
`ifdef IQ_STREAM_FRAMER_CHECKSUM_EN
        exp_q.push_back(8'h00 - s);
`endif
        model_seq = model_seq + 8'd1;
    endtask

    task automatic kick(input logic [63:0] d);
        @(negedge clk);
        dclk = 1'b0;
        @(negedge clk);
        data = d;
        dclk = 1'b1;
        @(negedge clk);
        chk("first_start_latency", {31'd0, tx_start}, 32'd1);
        dclk = 1'b0;
        data = {$urandom, $urandom};
    endtask

    task automatic send_frame(input logic [63:0] d);
        push_frame(d);
        kick(d);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_start || u_dly || tx_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_complete_timeout", {31'd0, n < 3000}, 32'd1);
        repeat (2) @(negedge clk);
        chk("busy_after_frame", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        en = 1'b1;
        dclk = 1'b0;
        data = '0;
        stall = 1'b0;
        model_seq = 8'h00;
        seen_seq = 8'h00;
        held = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_tx_start", {31'd0, tx_start}, 32'd0);
        chk("reset_tx_byte", {24'd0, tx_byte}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Known-answer frame
        exp_q.push_back(8'hAA); exp_q.push_back(8'h01); exp_q.push_back(8'h00);
        exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'h56);
        exp_q.push_back(8'h78); exp_q.push_back(8'h9A); exp_q.push_back(8'hBC);
        exp_q.push_back(8'hDE); exp_q.push_back(8'hF0);
`ifdef IQ_STREAM_FRAMER_CHECKSUM_EN
        exp_q.push_back(8'hC7);
`endif
        model_seq = 8'h01;
        kick(64'h1234_5678_9ABC_DEF0);
        wait_done();

        // Three edges during a frame are dropped; the frame is unaffected
        send_frame({$urandom, $urandom});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dclk = 1'b1;
            data = {$urandom, $urandom};
            @(negedge clk);
            dclk = 1'b0;
        end
        wait_done();
        chk("drop_cnt_three", {24'd0, drop_cnt}, 32'd3);

        // Edge with enable low: nothing happens
        @(negedge clk);
        en = 1'b0;
        dclk = 1'b1;
        @(negedge clk);
        dclk = 1'b0;
        repeat (30) @(negedge clk);
        chk("en_low_drop_cnt", {24'd0, drop_cnt}, 32'd3);
        chk("en_low_busy", {31'd0, busy}, 32'd0);
        en = 1'b1;

        // Enable dropped mid-frame: frame completes
        send_frame({$urandom, $urandom});
        @(negedge clk);
        en = 1'b0;
        wait_done();
        en = 1'b1;

        // Stall the UART so 300 edges land inside one frame
        send_frame({$urandom, $urandom});
        stall = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            dclk = 1'b1;
            @(negedge clk);
            dclk = 1'b0;
        end
        chk("drop_cnt_saturate", {24'd0, drop_cnt}, 32'd255);
        stall = 1'b0;
        wait_done();

        // Reset while payload byte 3 is being issued
        send_frame({$urandom, $urandom});
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!(tx_start && frame_pos == 6) && n < 2000);
        chk("reach_payload3_timeout", {31'd0, n < 2000}, 32'd1);
        dclk = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        chk("async_rst_tx_byte", {24'd0, tx_byte}, 32'd0);
        model_seq = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("dclk_high_after_reset_busy", {31'd0, busy}, 32'd0);

        // SEQ wraps on frame 257 after reset
        for (int f = 1; f <= 257; f++) begin
            send_frame({$urandom, $urandom});
            wait_done();
            if (f == 256) chk("seq_frame256", {24'd0, seen_seq}, 32'hFF);
            if (f == 257) chk("seq_frame257", {24'd0, seen_seq}, 32'h00);
        end

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
